// File: rtl/muldiv_sequencer_pkg.sv
// Shared decode constants for the multi-cycle MUL/DIV/MOD unit: ALU opcodes
// and the sequencer state encodings that the hazard unit decodes.
package muldiv_sequencer_pkg;

  localparam logic [3:0] ALU_MUL = 4'h8;
  localparam logic [3:0] ALU_DIV = 4'h9;
  localparam logic [3:0] ALU_MOD = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mds_state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for MUL, restoring division step for DIV/MOD.
module muldiv_step
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] x_next,
  output logic [XLEN-1:0] y_next
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;
  logic          fits;

  always_comb begin
    trial    = {acc, x[XLEN-1]};
    diff     = trial - {1'b0, y};
    fits     = (trial >= {1'b0, y});
    acc_next = acc;
    x_next   = x;
    y_next   = y;
    if (op == ALU_MUL) begin
      // x is the shifting multiplicand, y the multiplier consumed LSB first
      acc_next = acc + (y[0] ? x : '0);
      x_next   = {x[XLEN-2:0], 1'b0};
      y_next   = {1'b0, y[XLEN-1:1]};
    end else begin
      // x shifts the dividend out at the top and the quotient in at the bottom
      acc_next = fits ? diff[XLEN-1:0] : trial[XLEN-1:0];
      x_next   = {x[XLEN-2:0], fits};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV/MOD controller: valid/ready request port, iterative
// radix-2 engine, one-cycle response pulse.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             busy,
  output logic             resp_valid,
  output logic [XLEN-1:0]  resp_result,
  output logic [TAG_W-1:0] resp_tag
);

  localparam int CNT_W = $clog2(XLEN);

  mds_state_e       state;
  logic [3:0]       op;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  logic [TAG_W-1:0] tag;
  logic [XLEN-1:0]  acc;
  logic [XLEN-1:0]  x;
  logic [XLEN-1:0]  y;
  logic [XLEN-1:0]  res;
  logic [CNT_W-1:0] count;
  logic             q_sign;
  logic             r_sign;

  logic [XLEN-1:0]  acc_next;
  logic [XLEN-1:0]  x_next;
  logic [XLEN-1:0]  y_next;
  logic             req_legal;
  logic             req_divmod;

  assign req_ready  = (state == ST_IDLE) && !flush;
  assign busy       = (state != ST_IDLE);
  assign req_divmod = (req_op == ALU_DIV) || (req_op == ALU_MOD);
  assign req_legal  = (req_op == ALU_MUL) || req_divmod;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .op       (op),
    .acc      (acc),
    .x        (x),
    .y        (y),
    .acc_next (acc_next),
    .x_next   (x_next),
    .y_next   (y_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      op          <= '0;
      a           <= '0;
      b           <= '0;
      tag         <= '0;
      acc         <= '0;
      x           <= '0;
      y           <= '0;
      res         <= '0;
      count       <= '0;
      q_sign      <= 1'b0;
      r_sign      <= 1'b0;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      resp_tag    <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (req_valid) begin
              op  <= req_op;
              a   <= req_a;
              b   <= req_b;
              tag <= req_tag;
              // Illegal op and divide-by-zero skip the engine entirely
              if (!req_legal) begin
                res   <= '0;
                state <= ST_DONE;
              end else if (req_divmod && (req_b == '0)) begin
                res   <= (req_op == ALU_DIV) ? '1 : req_a;
                state <= ST_DONE;
              end else begin
                state <= ST_PREP;
              end
            end
          end
          ST_PREP: begin
            if (op == ALU_MUL) begin
              x <= a;
              y <= b;
            end else begin
              x <= abs32(a);
              y <= abs32(b);
            end
            q_sign <= a[XLEN-1] ^ b[XLEN-1];
            r_sign <= a[XLEN-1];
            acc    <= '0;
            count  <= '0;
            state  <= ST_ITER;
          end
          ST_ITER: begin
            acc   <= acc_next;
            x     <= x_next;
            y     <= y_next;
            count <= count + 1'b1;
            if (count == CNT_W'(XLEN - 1)) state <= ST_FIX;
          end
          ST_FIX: begin
            if (op == ALU_DIV)      res <= q_sign ? (~x + 1'b1) : x;
            else if (op == ALU_MOD) res <= r_sign ? (~acc + 1'b1) : acc;
            else                    res <= acc;
            state <= ST_DONE;
          end
          ST_DONE: begin
            resp_valid  <= 1'b1;
            resp_result <= res;
            resp_tag    <= tag;
            state       <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
